// File: rtl/binary_morph_3x3.sv
// rtl/binary_morph_3x3.sv - 3x3 binary erosion/dilation with 2-cycle sync alignment; optional border forcing via BINARY_MORPH_BORDER_EN
module binary_morph_3x3 #(
  parameter int   IMG_WIDTH  = 640,
  parameter int   IMG_HEIGHT = 480,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic matrix_frame_vsync,
  input  logic matrix_frame_hsync,
  input  logic matrix_frame_valid,
  input  logic matrix_p11,
  input  logic matrix_p12,
  input  logic matrix_p13,
  input  logic matrix_p21,
  input  logic matrix_p22,
  input  logic matrix_p23,
  input  logic matrix_p31,
  input  logic matrix_p32,
  input  logic matrix_p33,
  output logic post_frame_vsync,
  output logic post_frame_hsync,
  output logic post_frame_valid,
  output logic post_img_bit
);

  logic       vs_d1;
  logic       hs_d1;
  logic       vl_d1;
  logic       mode_lat;
  logic       res1;
  logic       bit1;
  logic [8:0] taps;
  logic       ero;
  logic       dil;

  assign taps = {matrix_p11, matrix_p12, matrix_p13,
                 matrix_p21, matrix_p22, matrix_p23,
                 matrix_p31, matrix_p32, matrix_p33};
  assign ero  = &taps;
  assign dil  = |taps;

  // Latch the operation once per frame, on the vsync rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_lat <= 1'b0;
    end else if (matrix_frame_vsync && !vs_d1) begin
      mode_lat <= mode;
    end
  end

  // Two-deep sync shift register; the first stage doubles as edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1            <= 1'b0;
      hs_d1            <= 1'b0;
      vl_d1            <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_valid <= 1'b0;
    end else begin
      vs_d1            <= matrix_frame_vsync;
      hs_d1            <= matrix_frame_hsync;
      vl_d1            <= matrix_frame_valid;
      post_frame_vsync <= vs_d1;
      post_frame_hsync <= hs_d1;
      post_frame_valid <= vl_d1;
    end
  end

  // Stage 1 morphology result, held across valid gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res1 <= 1'b0;
    end else if (matrix_frame_valid) begin
      res1 <= mode_lat ? dil : ero;
    end
  end

`ifdef BINARY_MORPH_BORDER_EN
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          brd1;
  logic          hs_fall;

  assign hs_fall = hs_d1 && !matrix_frame_hsync;

  // Column position within the line; cleared outside hsync, saturates at the last column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (!matrix_frame_hsync) begin
      col_cnt <= '0;
    end else if (matrix_frame_valid && (col_cnt != CW'(IMG_WIDTH - 1))) begin
      col_cnt <= col_cnt + CW'(1);
    end
  end

  // Line position within the frame; vsync low clears and wins over a coincident hsync fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
    end else if (!matrix_frame_vsync) begin
      row_cnt <= '0;
    end else if (hs_fall && (row_cnt != RW'(IMG_HEIGHT - 1))) begin
      row_cnt <= row_cnt + RW'(1);
    end
  end

  // Border flag for this pixel, taken from the counters before they advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brd1 <= 1'b0;
    end else if (matrix_frame_valid) begin
      brd1 <= (32'(col_cnt) < 32'd2) || (32'(row_cnt) < 32'd2);
    end
  end

  assign bit1 = brd1 ? BORDER_VAL : res1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{BORDER_VAL, IMG_WIDTH[0], IMG_HEIGHT[0]};
  assign bit1       = res1;
`endif

  // Stage 2 output bit, forced low whenever the delayed strobe is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_bit <= 1'b0;
    end else begin
      post_img_bit <= vl_d1 ? bit1 : 1'b0;
    end
  end

endmodule
